// File: rtl/kasumi_mem_pkg.sv
// Shared definitions for the integrated memory controller.
// Holds RV32 funct3 codes, the controller FSM encoding, address-region
// decode and the byte-lane helpers used for stores, loads and MMIO.
package kasumi_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_WAIT
    } state_e;

    typedef enum logic [1:0] {
        RGN_PROG,
        RGN_DATA,
        RGN_MMIO
    } region_e;

    // top = address bits [14:13]
    function automatic region_e region_of(input logic [1:0] top);
        if (top[1])      return RGN_MMIO;
        else if (top[0]) return RGN_DATA;
        else             return RGN_PROG;
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // size = funct3[1:0]: 0 byte, 1 half, 2 word
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == 2'd1) && off[0]) || ((size == 2'd2) && (off != 2'd0));
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 4'b0001 << off;
            2'd1:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the LSB-aligned store data into every lane it could land in.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'd0:    return {4{w[7:0]}};
            2'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{s[7]}}, s[7:0]};
            F3_H:    return {{16{s[15]}}, s[15:0]};
            F3_BU:   return {24'd0, s[7:0]};
            F3_HU:   return {16'd0, s[15:0]};
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/integrated_mem_ctrl_mem_bank.sv
// Word-wide RAM with per-byte write enables.
// Port A: read/write, read data registered when a_en_i (read-before-write).
// Port B: read-only, registered every cycle.
//   clk_i                          clock
//   a_en_i, a_be_i, a_addr_i,
//   a_wdata_i, a_rdata_o           read/write port
//   b_addr_i, b_rdata_o            read-only port
module mem_bank #(
    parameter int AW = 11
) (
    input  logic          clk_i,
    input  logic          a_en_i,
    input  logic [3:0]    a_be_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [31:0]   a_wdata_i,
    output logic [31:0]   a_rdata_o,
    input  logic [AW-1:0] b_addr_i,
    output logic [31:0]   b_rdata_o
);

    logic [31:0] mem_q [2**AW];
    logic [31:0] a_rdata_q;
    logic [31:0] b_rdata_q;

    always_ff @(posedge clk_i) begin
        if (a_en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be_i[i]) mem_q[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
            end
            a_rdata_q <= mem_q[a_addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        b_rdata_q <= mem_q[b_addr_i];
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/integrated_mem_ctrl.sv
// Unified memory subsystem: program memory (with independent fetch port),
// data memory and NUM_REG_CH MMIO channels behind a req/ack handshake.
//   clk, reset (async, active-low)
//   imem_addr / imem_rdata          fetch port, 1-cycle read, NOP outside prog
//   d_req, d_we, d_funct3, d_addr,
//   d_wdata, d_ready                data request side, accepted on d_req & d_ready
//   d_rvalid, d_rdata, d_err        one response pulse per accepted request
//   prog_write_busy                 store to program memory in flight
//   reg_req, reg_we, reg_addr,
//   reg_wdata, reg_be               MMIO request, held while waiting
//   reg_ack, reg_rdata              per-channel completion and read data
module integrated_mem_ctrl
    import kasumi_mem_pkg::*;
#(
    parameter int PROG_AW     = 11,
    parameter int DATA_AW     = 11,
    parameter int NUM_REG_CH  = 4,
    parameter int REG_AW      = 12,
    parameter int REG_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             imem_addr,
    output logic [31:0]             imem_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [2:0]              d_funct3,
    input  logic [31:0]             d_addr,
    input  logic [31:0]             d_wdata,
    output logic                    d_ready,
    output logic                    d_rvalid,
    output logic [31:0]             d_rdata,
    output logic                    d_err,
    output logic                    prog_write_busy,
    output logic [NUM_REG_CH-1:0]   reg_req,
    output logic                    reg_we,
    output logic [REG_AW-1:0]       reg_addr,
    output logic [31:0]             reg_wdata,
    output logic [3:0]              reg_be,
    input  logic [NUM_REG_CH-1:0]   reg_ack,
    input  logic [32*NUM_REG_CH-1:0] reg_rdata
);

    state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic pw_q, nop_q;

    // Request attributes captured at accept; data only, no reset needed.
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              we_q;
    region_e           src_q;
    logic [1:0]        ch_q;
    logic [REG_AW-1:0] reg_addr_q;
    logic [31:0]       reg_wdata_q;
    logic [3:0]        be_q;
    logic [31:0]       mmio_rd_q;

    region_e    rgn;
    logic [1:0] off;
    logic       accept, acc_err, mem_ok, prog_en, data_en, pw_now;
    logic       ack_sel, timeout;
    logic [3:0] be, wr_be;
    logic [31:0] wlanes, prog_a_rd, prog_b_rd, data_a_rd, data_b_rd, src_word;
    logic       unused_ok;

    assign accept  = d_req && (state_q == ST_IDLE);
    assign rgn     = region_of(d_addr[14:13]);
    assign off     = d_addr[1:0];
    assign acc_err = !funct3_legal(d_we, d_funct3) || misaligned(d_funct3[1:0], off) ||
                     ((rgn == RGN_MMIO) && (int'(d_addr[13:12]) >= NUM_REG_CH));
    assign mem_ok  = accept && !acc_err;
    assign prog_en = mem_ok && (rgn == RGN_PROG);
    assign data_en = mem_ok && (rgn == RGN_DATA);
    assign be      = lane_be(d_funct3[1:0], off);
    assign wr_be   = d_we ? be : 4'b0000;
    assign wlanes  = lane_wdata(d_funct3[1:0], d_wdata);
    assign pw_now  = prog_en && d_we;

    assign ack_sel = reg_ack[ch_q];
    assign timeout = (cnt_q + 8'd1) == 8'(REG_TIMEOUT);

    mem_bank #(.AW(PROG_AW)) u_prog (
        .clk_i     (clk),
        .a_en_i    (prog_en),
        .a_be_i    (wr_be),
        .a_addr_i  (d_addr[PROG_AW+1:2]),
        .a_wdata_i (wlanes),
        .a_rdata_o (prog_a_rd),
        .b_addr_i  (imem_addr[PROG_AW+1:2]),
        .b_rdata_o (prog_b_rd)
    );

    mem_bank #(.AW(DATA_AW)) u_data (
        .clk_i     (clk),
        .a_en_i    (data_en),
        .a_be_i    (wr_be),
        .a_addr_i  (d_addr[DATA_AW+1:2]),
        .a_wdata_i (wlanes),
        .a_rdata_o (data_a_rd),
        .b_addr_i  ({DATA_AW{1'b0}}),
        .b_rdata_o (data_b_rd)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    err_d   = acc_err;
                    cnt_d   = 8'd0;
                    state_d = (!acc_err && (rgn == RGN_MMIO)) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (ack_sel) begin
                    state_d = ST_RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            pw_q    <= 1'b0;
            nop_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pw_q    <= pw_now;
            nop_q   <= region_of(imem_addr[14:13]) != RGN_PROG;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            f3_q        <= d_funct3;
            off_q       <= off;
            we_q        <= d_we;
            src_q       <= rgn;
            ch_q        <= d_addr[13:12];
            reg_addr_q  <= d_addr[REG_AW-1:0];
            reg_wdata_q <= wlanes;
            be_q        <= be;
        end
        if ((state_q == ST_WAIT) && ack_sel) mmio_rd_q <= reg_rdata[32*ch_q +: 32];
    end

    always_comb begin
        case (src_q)
            RGN_PROG: src_word = prog_a_rd;
            RGN_DATA: src_word = data_a_rd;
            default:  src_word = mmio_rd_q;
        endcase
    end

    always_comb begin
        for (int c = 0; c < NUM_REG_CH; c++) begin
            reg_req[c] = (state_q == ST_WAIT) && (ch_q == 2'(c));
        end
    end

    assign d_ready         = state_q == ST_IDLE;
    assign d_rvalid        = state_q == ST_RESP;
    assign d_err           = d_rvalid && err_q;
    assign d_rdata         = (d_rvalid && !err_q && !we_q) ? load_extend(f3_q, off_q, src_word) : 32'd0;
    assign prog_write_busy = pw_now || pw_q;
    assign imem_rdata      = nop_q ? NOP_INSN : prog_b_rd;
    assign reg_we          = (state_q == ST_WAIT) && we_q;
    assign reg_be          = (state_q == ST_WAIT) ? be_q : 4'b0000;
    assign reg_addr        = reg_addr_q;
    assign reg_wdata       = reg_wdata_q;

    assign unused_ok = ^{imem_addr[31:15], imem_addr[1:0], d_addr[31:15], data_b_rd};

endmodule

// File: tb/tb_integrated_mem_ctrl.sv
module tb_integrated_mem_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  imem_addr = 32'd0;
    logic [31:0]  imem_rdata;
    logic         d_req = 1'b0;
    logic         d_we = 1'b0;
    logic [2:0]   d_funct3 = 3'd0;
    logic [31:0]  d_addr = 32'd0;
    logic [31:0]  d_wdata = 32'd0;
    logic         d_ready, d_rvalid, d_err, prog_write_busy;
    logic [31:0]  d_rdata;
    logic [3:0]   reg_req;
    logic         reg_we;
    logic [11:0]  reg_addr;
    logic [31:0]  reg_wdata;
    logic [3:0]   reg_be;
    logic [3:0]   reg_ack = 4'd0;
    logic [127:0] reg_rdata = 128'd0;

    int passed = 0;
    int total  = 0;

    integrated_mem_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .d_req           (d_req),
        .d_we            (d_we),
        .d_funct3        (d_funct3),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_ready         (d_ready),
        .d_rvalid        (d_rvalid),
        .d_rdata         (d_rdata),
        .d_err           (d_err),
        .prog_write_busy (prog_write_busy),
        .reg_req         (reg_req),
        .reg_we          (reg_we),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_be          (reg_be),
        .reg_ack         (reg_ack),
        .reg_rdata       (reg_rdata)
    );

    always #5 clk = ~clk;

    // Issues one request at a negedge and waits for its response pulse.
    // Returns at the negedge after the response (controller back in IDLE).
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output logic saw_req);
        d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
        @(negedge clk);
        d_req = 1'b0;
        lat = 1;
        saw_req = |reg_req;
        while (!d_rvalid && lat < 40) begin
            @(negedge clk);
            lat++;
            saw_req = saw_req | (|reg_req);
        end
        rdata = d_rdata;
        err = d_err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (d_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", d_ready); else passed++;
        total++; if (d_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", d_rvalid); else passed++;
        total++; if (d_err !== 1'b0) $display("FAIL rst_err: got %b want 0", d_err); else passed++;
        total++; if (d_rdata !== 32'd0) $display("FAIL rst_rdata: got %h want 0", d_rdata); else passed++;
        total++; if (imem_rdata !== 32'h0000_0013) $display("FAIL rst_imem: got %h want 00000013", imem_rdata); else passed++;
        total++; if (prog_write_busy !== 1'b0) $display("FAIL rst_pwb: got %b want 0", prog_write_busy); else passed++;
        total++; if (reg_req !== 4'd0) $display("FAIL rst_reg_req: got %b want 0000", reg_req); else passed++;
        total++; if (reg_we !== 1'b0 || reg_be !== 4'd0) $display("FAIL rst_reg_we_be: got %b/%b want 0/0000", reg_we, reg_be); else passed++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; logic sr;
        access(1'b1, 3'd2, 32'h2004, 32'hDEAD_BEEF, rd, er, lat, sr);
        total++; if (lat != 1 || er !== 1'b0 || rd !== 32'd0) $display("FAIL sw_resp: got lat=%0d err=%b rdata=%h want 1/0/0", lat, er, rd); else passed++;
        access(1'b0, 3'd2, 32'h2004, 32'd0, rd, er, lat, sr);
        total++; if (lat != 1) $display("FAIL lw_latency: got %0d want 1", lat); else passed++;
        total++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) $display("FAIL lw_data: got %h err=%b want deadbeef err=0", rd, er); else passed++;
    endtask

    task automatic test_extend();
        logic [31:0] rd; logic er; int lat; logic sr;
        access(1'b1, 3'd2, 32'h2004, 32'h80FF_0000, rd, er, lat, sr);
        access(1'b0, 3'd0, 32'h2007, 32'd0, rd, er, lat, sr);
        total++; if (rd !== 32'hFFFF_FF80) $display("FAIL lb: got %h want ffffff80", rd); else passed++;
        access(1'b0, 3'd4, 32'h2007, 32'd0, rd, er, lat, sr);
        total++; if (rd !== 32'h0000_0080) $display("FAIL lbu: got %h want 00000080", rd); else passed++;
        access(1'b0, 3'd1, 32'h2006, 32'd0, rd, er, lat, sr);
        total++; if (rd !== 32'hFFFF_80FF) $display("FAIL lh: got %h want ffff80ff", rd); else passed++;
        access(1'b0, 3'd5, 32'h2006, 32'd0, rd, er, lat, sr);
        total++; if (rd !== 32'h0000_80FF) $display("FAIL lhu: got %h want 000080ff", rd); else passed++;
        access(1'b1, 3'd0, 32'h2005, 32'hAAAA_AA55, rd, er, lat, sr);
        access(1'b0, 3'd2, 32'h2004, 32'd0, rd, er, lat, sr);
        total++; if (rd !== 32'h80FF_5500) $display("FAIL sb_merge: got %h want 80ff5500", rd); else passed++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; logic sr;
        access(1'b1, 3'd2, 32'h2000, 32'h1122_3344, rd, er, lat, sr);
        access(1'b0, 3'd2, 32'h2002, 32'd0, rd, er, lat, sr);
        total++; if (lat != 1 || er !== 1'b1 || rd !== 32'd0) $display("FAIL lw_misaligned: got lat=%0d err=%b rdata=%h want 1/1/0", lat, er, rd); else passed++;
        access(1'b1, 3'd2, 32'h2002, 32'hFFFF_FFFF, rd, er, lat, sr);
        total++; if (er !== 1'b1) $display("FAIL sw_misaligned: got err=%b want 1", er); else passed++;
        access(1'b1, 3'd1, 32'h2001, 32'hFFFF_FFFF, rd, er, lat, sr);
        total++; if (er !== 1'b1) $display("FAIL sh_misaligned: got err=%b want 1", er); else passed++;
        access(1'b0, 3'd2, 32'h2000, 32'd0, rd, er, lat, sr);
        total++; if (rd !== 32'h1122_3344 || er !== 1'b0) $display("FAIL word_unchanged: got %h err=%b want 11223344 err=0", rd, er); else passed++;
        access(1'b0, 3'd3, 32'h2000, 32'd0, rd, er, lat, sr);
        total++; if (er !== 1'b1 || rd !== 32'd0) $display("FAIL funct3_3: got err=%b rdata=%h want 1/0", er, rd); else passed++;
        access(1'b1, 3'd4, 32'h2000, 32'd0, rd, er, lat, sr);
        total++; if (er !== 1'b1) $display("FAIL store_funct3_4: got err=%b want 1", er); else passed++;
        access(1'b1, 3'd2, 32'h4102, 32'h1234_5678, rd, er, lat, sr);
        total++; if (er !== 1'b1 || sr !== 1'b0 || lat != 1) $display("FAIL mmio_misaligned: got err=%b req_seen=%b lat=%0d want 1/0/1", er, sr, lat); else passed++;
    endtask

    task automatic test_mmio();
        int n;
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'd2; d_addr = 32'h4104; d_wdata = 32'h1234_5678;
        @(negedge clk);
        d_req = 1'b0;
        total++; if (reg_req !== 4'b0001 || reg_we !== 1'b1) $display("FAIL mmio_req: got %b we=%b want 0001 we=1", reg_req, reg_we); else passed++;
        total++; if (reg_be !== 4'hF || reg_addr !== 12'h104) $display("FAIL mmio_be_addr: got %h/%h want f/104", reg_be, reg_addr); else passed++;
        total++; if (reg_wdata !== 32'h1234_5678 || d_ready !== 1'b0) $display("FAIL mmio_wdata: got %h ready=%b want 12345678 ready=0", reg_wdata, d_ready); else passed++;
        n = 0;
        while (reg_req != 4'd0 && n < 40) begin
            n++;
            if (n == 3) reg_ack = 4'b0001;
            @(negedge clk);
        end
        reg_ack = 4'd0;
        total++; if (n != 3) $display("FAIL mmio_hold: got %0d req cycles want 3", n); else passed++;
        total++; if (d_rvalid !== 1'b1 || d_err !== 1'b0) $display("FAIL mmio_resp: got rvalid=%b err=%b want 1/0", d_rvalid, d_err); else passed++;
        @(negedge clk);

        // LH from channel 1; an ack on channel 0 must not complete it
        reg_rdata[63:32] = 32'hA5A5_1234;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'd1; d_addr = 32'h500A;
        @(negedge clk);
        d_req = 1'b0;
        total++; if (reg_req !== 4'b0010 || reg_be !== 4'b1100 || reg_addr !== 12'h00A || reg_we !== 1'b0)
            $display("FAIL mmio_ch1_req: got req=%b be=%b addr=%h we=%b want 0010/1100/00a/0", reg_req, reg_be, reg_addr, reg_we); else passed++;
        reg_ack = 4'b0001;
        @(negedge clk);
        total++; if (reg_req !== 4'b0010 || d_rvalid !== 1'b0) $display("FAIL mmio_wrong_ack: got req=%b rvalid=%b want 0010/0", reg_req, d_rvalid); else passed++;
        reg_ack = 4'b0010;
        @(negedge clk);
        reg_ack = 4'd0;
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hFFFF_A5A5 || d_err !== 1'b0)
            $display("FAIL mmio_lh: got rvalid=%b rdata=%h err=%b want 1/ffffa5a5/0", d_rvalid, d_rdata, d_err); else passed++;
        @(negedge clk);

        // SB lane replication
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'd0; d_addr = 32'h4003; d_wdata = 32'h0000_00AB;
        @(negedge clk);
        d_req = 1'b0;
        total++; if (reg_be !== 4'b1000 || reg_wdata !== 32'hABAB_ABAB) $display("FAIL mmio_sb: got be=%b wdata=%h want 1000/abababab", reg_be, reg_wdata); else passed++;
        reg_ack = 4'b0001;
        @(negedge clk);
        reg_ack = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'd2; d_addr = 32'h4104; d_wdata = 32'h0;
        @(negedge clk);
        d_req = 1'b0;
        n = 0;
        while (reg_req != 4'd0 && n < 60) begin
            n++;
            @(negedge clk);
        end
        total++; if (n != 15) $display("FAIL timeout_wait: got %0d req cycles want 15", n); else passed++;
        total++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'd0)
            $display("FAIL timeout_resp: got rvalid=%b err=%b rdata=%h want 1/1/0", d_rvalid, d_err, d_rdata); else passed++;
        @(negedge clk);
    endtask

    task automatic test_prog_write();
        logic [31:0] rd; logic er; int lat; logic sr;
        access(1'b1, 3'd2, 32'h0010, 32'hCAFE_0001, rd, er, lat, sr);
        imem_addr = 32'h0010;
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'd2; d_addr = 32'h0010; d_wdata = 32'h0010_0093;
        #1;
        total++; if (prog_write_busy !== 1'b1) $display("FAIL pwb_accept: got %b want 1", prog_write_busy); else passed++;
        @(negedge clk);
        d_req = 1'b0;
        total++; if (imem_rdata !== 32'hCAFE_0001) $display("FAIL fetch_old: got %h want cafe0001", imem_rdata); else passed++;
        total++; if (prog_write_busy !== 1'b1) $display("FAIL pwb_second: got %b want 1", prog_write_busy); else passed++;
        @(negedge clk);
        total++; if (imem_rdata !== 32'h0010_0093) $display("FAIL fetch_new: got %h want 00100093", imem_rdata); else passed++;
        total++; if (prog_write_busy !== 1'b0) $display("FAIL pwb_clear: got %b want 0", prog_write_busy); else passed++;
        imem_addr = 32'h2000;
        @(negedge clk);
        total++; if (imem_rdata !== 32'h0000_0013) $display("FAIL fetch_outside: got %h want 00000013", imem_rdata); else passed++;
        imem_addr = 32'h0;
        access(1'b0, 3'd2, 32'h0010, 32'd0, rd, er, lat, sr);
        total++; if (rd !== 32'h0010_0093) $display("FAIL prog_load: got %h want 00100093", rd); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        pat = 4'd0;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'd2; d_addr = 32'h2004;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = d_rvalid;
        end
        d_req = 1'b0;
        total++; if (pat !== 4'b0101) $display("FAIL back_to_back: got rvalid pattern %b want 0101", pat); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        logic seen;
        logic [31:0] rd; logic er; int lat; logic sr;
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'd2; d_addr = 32'h4104; d_wdata = 32'h0;
        @(negedge clk);
        d_req = 1'b0;
        total++; if (reg_req !== 4'b0001) $display("FAIL rmw_pending: got %b want 0001", reg_req); else passed++;
        #2 reset = 1'b0;
        #1;
        total++; if (reg_req !== 4'd0 || d_ready !== 1'b1) $display("FAIL rmw_async: got req=%b ready=%b want 0000/1", reg_req, d_ready); else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | d_rvalid | (|reg_req);
        end
        total++; if (seen !== 1'b0) $display("FAIL rmw_discard: got stray response/req=%b want 0", seen); else passed++;
        access(1'b0, 3'd2, 32'h2004, 32'd0, rd, er, lat, sr);
        total++; if (rd !== 32'h80FF_5500 || lat != 1) $display("FAIL rmw_mem_kept: got %h lat=%0d want 80ff5500 lat=1", rd, lat); else passed++;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_extend();
        test_errors();
        test_mmio();
        test_timeout();
        test_prog_write();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
